// File: rtl/controller.sv
// controller: multi-cycle 16-bit core with a 4 x 16 register file and a unified 256 x 16 memory.
// Optional CTRL_HALT_EN: opcode 111 becomes a terminal HALT after its ready pulse.

module controller_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ra_i,
  input  logic [1:0]  rb_i,
  input  logic        we_i,
  input  logic [1:0]  wa_i,
  input  logic [15:0] wd_i,
  output logic [15:0] qa_o,
  output logic [15:0] qb_o
);
  logic signed [15:0] registers [0:3];

  // Plain always: benches preload this array through hierarchy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) registers[i] <= '0;
    end else if (we_i) begin
      registers[wa_i] <= wd_i;
    end
  end

  assign qa_o = registers[ra_i];
  assign qb_o = registers[rb_i];
endmodule

module controller_mem (
  input  logic        clk,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic [15:0] wd_i,
  output logic [15:0] rd_o
);
  logic [15:0] mem [0:255];
  logic [15:0] rd_q;

  always @(posedge clk) begin
    if (we_i) mem[addr_i] <= wd_i;
    rd_q <= mem[addr_i];
  end

  assign rd_o = rd_q;
endmodule

module controller #(
  parameter int CLK_PERIOD = 2
) (
  input logic clk,
  input logic reset
);
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
`ifdef CTRL_HALT_EN
  localparam logic [2:0] OP_HALT  = 3'b111;
`endif

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, DONE
`ifdef CTRL_HALT_EN
    , HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  PC;
  logic        ready;
  logic [15:0] ir_q, a_q, b_q, x_q, y_q, acc_q, res_q;
  logic [7:0]  ea_q;
  logic [3:0]  cnt_q;
  logic        neg_q, dz_q;

  logic [15:0] mem_rd, rf_qa, rf_qb, inst, mag_a, mag_b;
  logic [15:0] mul_acc, div_q, wb_data;
  logic [16:0] rem_sh, div_diff;
  logic [2:0]  op;
  logic [1:0]  rb_sel;
  logic [7:0]  mem_addr;
  logic        rf_we, mem_we, div_ge;

  // CLK_PERIOD only shapes simulation timing; the logic never depends on it.
  if (CLK_PERIOD <= 0) begin : g_bad_clk_period
  end

  // The fetched word is live on the memory output during DECODE, latched afterwards.
  assign inst   = (state_q == DECODE) ? mem_rd : ir_q;
  assign op     = inst[15:13];
  assign rb_sel = (op == OP_STORE) ? inst[12:11] : inst[8:7];

  controller_rf rf (
    .clk   (clk),
    .reset (reset),
    .ra_i  (inst[10:9]),
    .rb_i  (rb_sel),
    .we_i  (rf_we),
    .wa_i  (ir_q[12:11]),
    .wd_i  (wb_data),
    .qa_o  (rf_qa),
    .qb_o  (rf_qb)
  );

  controller_mem mem (
    .clk    (clk),
    .addr_i (mem_addr),
    .we_i   (mem_we),
    .wd_i   (b_q),
    .rd_o   (mem_rd)
  );

  assign mag_a    = rf_qa[15] ? -rf_qa : rf_qa;
  assign mag_b    = rf_qb[15] ? -rf_qb : rf_qb;
  assign mul_acc  = acc_q + (y_q[0] ? x_q : 16'd0);
  // Remainder stays below the divisor, so bit 16 of the difference is its sign.
  assign rem_sh   = {acc_q, x_q[15]};
  assign div_diff = rem_sh - {1'b0, y_q};
  assign div_ge   = ~div_diff[16];
  assign div_q    = dz_q ? 16'hFFFF : (neg_q ? -x_q : x_q);

  always_comb begin
    wb_data = mem_rd;
    case (op)
      OP_ADD, OP_SUB: wb_data = res_q;
      OP_MUL:         wb_data = acc_q;
      OP_DIV:         wb_data = div_q;
      default:        wb_data = mem_rd;
    endcase
  end

  assign rf_we    = (state_q == WB) && ((op[2] == 1'b0) || (op == OP_LOAD));
  assign mem_we   = (state_q == MEM) && (op == OP_STORE);
  assign mem_addr = (state_q == MEM) ? ea_q : PC;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC: begin
        if (op == OP_MUL || op == OP_DIV) begin
          if (cnt_q == 4'd15) state_d = WB;
        end else if (op == OP_LOAD || op == OP_STORE) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM:    state_d = WB;
      WB:     state_d = DONE;
      DONE: begin
        state_d = FETCH;
`ifdef CTRL_HALT_EN
        if (op == OP_HALT) state_d = HALT;
`endif
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      PC    <= '0;
      ready <= 1'b0;
    end else begin
      if (state_q == DECODE) PC <= PC + 8'd1;
      ready <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
      ea_q  <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      case (state_q)
        DECODE: begin
          ir_q  <= mem_rd;
          a_q   <= rf_qa;
          b_q   <= rf_qb;
          cnt_q <= '0;
          acc_q <= '0;
          neg_q <= rf_qa[15] ^ rf_qb[15];
          dz_q  <= (rf_qb == 16'd0);
          if (op == OP_DIV) begin
            x_q <= mag_a;
            y_q <= mag_b;
          end else begin
            x_q <= rf_qa;
            y_q <= rf_qb;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + 4'd1;
          res_q <= (op == OP_SUB) ? a_q - b_q : a_q + b_q;
          ea_q  <= a_q[7:0] + ir_q[7:0];
          if (op == OP_MUL) begin
            acc_q <= mul_acc;
            x_q   <= {x_q[14:0], 1'b0};
            y_q   <= {1'b0, y_q[15:1]};
          end else if (op == OP_DIV) begin
            acc_q <= div_ge ? div_diff[15:0] : rem_sh[15:0];
            x_q   <= {x_q[14:0], div_ge};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for controller: program run, arithmetic corners, PC wrap, reset abort, opcode 111.
module tb_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  controller #(.CLK_PERIOD(2)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #1 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 7'd0};
  endfunction

  function automatic logic [15:0] enc_m(input logic [2:0] op, input logic [1:0] rt,
                                        input logic [1:0] base, input logic [8:0] imm);
    return {op, rt, base, imm};
  endfunction

  task automatic fill_nop;
    for (int i = 0; i < 256; i++) dut.mem.mem[i] = 16'hC000;
  endtask

  // Leaves the bench on the falling edge right after reset is released.
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < 200 && !ok) begin
      @(negedge clk);
      cycles++;
      if (dut.ready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int ready_hi;
    ready_hi = 0;
    fill_nop();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dut.ready !== 1'b0) ready_hi++;
    end
    $display("reset txn: PC=%h ready=%b", dut.PC, dut.ready);
    total++;
    if (dut.PC !== 8'd0) begin bad++; $display("FAIL reset_pc: got %h, required 00", dut.PC); end
    total++;
    if (ready_hi !== 0) begin bad++; $display("FAIL reset_ready: high %0d cycles, required 0", ready_hi); end
    for (int r = 0; r < 4; r++) begin
      total++;
      if (dut.rf.registers[r] !== 16'sd0) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h, required 0000", r, dut.rf.registers[r]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_program;
    logic [15:0] prog [11];
    int          loc  [11];
    logic [15:0] expv [11];
    logic [15:0] obs;
    int cyc;
    bit ok;
    prog[0]  = enc_r(3'b000, 2'd1, 2'd0, 2'd0);  loc[0]  = 1; expv[0]  = 16'hFF86;
    prog[1]  = enc_r(3'b011, 2'd2, 2'd1, 2'd2);  loc[1]  = 2; expv[1]  = 16'hFFE8;
    prog[2]  = enc_r(3'b001, 2'd0, 2'd2, 2'd0);  loc[2]  = 0; expv[2]  = 16'h0025;
    prog[3]  = enc_r(3'b010, 2'd1, 2'd3, 2'd0);  loc[3]  = 1; expv[3]  = 16'h0172;
    prog[4]  = enc_r(3'b011, 2'd3, 2'd0, 2'd3);  loc[4]  = 3; expv[4]  = 16'h0003;
    prog[5]  = enc_r(3'b000, 2'd3, 2'd3, 2'd1);  loc[5]  = 3; expv[5]  = 16'h0175;
    prog[6]  = enc_r(3'b001, 2'd1, 2'd0, 2'd3);  loc[6]  = 1; expv[6]  = 16'hFEB0;
    prog[7]  = enc_r(3'b010, 2'd1, 2'd0, 2'd2);  loc[7]  = 1; expv[7]  = 16'hFC88;
    prog[8]  = 16'hA780;                         loc[8]  = 4; expv[8]  = 16'h0025;
    prog[9]  = enc_m(3'b100, 2'd2, 2'd0, 9'd208); loc[9] = 2; expv[9]  = 16'h0025;
    prog[10] = enc_r(3'b001, 2'd0, 2'd2, 2'd1);  loc[10] = 0; expv[10] = 16'h039D;
    fill_nop();
    do_reset();
    for (int i = 0; i < 11; i++) dut.mem.mem[i] = prog[i];
    dut.rf.registers[0] = 16'hFFC3;
    dut.rf.registers[1] = 16'h0000;
    dut.rf.registers[2] = 16'h0005;
    dut.rf.registers[3] = 16'h000A;
    for (int i = 0; i < 11; i++) begin
      wait_ready(cyc, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL prog_timeout: txn %0d saw no ready in %0d cycles, required a pulse", i, cyc);
        return;
      end
      obs = (loc[i] < 4) ? dut.rf.registers[loc[i]] : dut.mem.mem[245];
      $display("prog txn %0d: instr=%h result=%h cycles=%0d", i, prog[i], obs, cyc);
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("FAIL prog_result%0d: got %h, required %h", i, obs, expv[i]);
      end
      if (i > 0) begin
        total++;
        if (cyc < 4) begin
          bad++;
          $display("FAIL prog_gap%0d: pulse %0d cycles after previous, required >= 4", i, cyc);
        end
      end
    end
    total++;
    if (dut.PC !== 8'd11) begin bad++; $display("FAIL prog_pc: got %0d, required 11", dut.PC); end
    total++;
    if (dut.rf.registers[1] !== 16'hFC88) begin bad++; $display("FAIL prog_final_x1: got %h, required fc88", dut.rf.registers[1]); end
    total++;
    if (dut.rf.registers[2] !== 16'h0025) begin bad++; $display("FAIL prog_final_x2: got %h, required 0025", dut.rf.registers[2]); end
    total++;
    if (dut.rf.registers[3] !== 16'h0175) begin bad++; $display("FAIL prog_final_x3: got %h, required 0175", dut.rf.registers[3]); end
  endtask

  task automatic test_div_edges;
    logic [15:0] prog [6];
    int          loc  [6];
    logic [15:0] expv [6];
    logic [15:0] obs;
    int cyc;
    bit ok;
    prog[0] = enc_r(3'b011, 2'd1, 2'd2, 2'd3);     loc[0] = 1; expv[0] = 16'hFFFF;
    prog[1] = enc_r(3'b011, 2'd2, 2'd0, 2'd1);     loc[1] = 2; expv[1] = 16'h8000;
    prog[2] = enc_m(3'b100, 2'd3, 2'd3, 9'd100);   loc[2] = 3; expv[2] = 16'h012C;
    prog[3] = enc_r(3'b010, 2'd0, 2'd3, 2'd3);     loc[3] = 0; expv[3] = 16'h5F90;
    prog[4] = enc_m(3'b101, 2'd0, 2'd3, 9'h1CE);   loc[4] = 4; expv[4] = 16'h5F90;
    prog[5] = 16'hC000;                            loc[5] = 0; expv[5] = 16'h5F90;
    fill_nop();
    do_reset();
    for (int i = 0; i < 6; i++) dut.mem.mem[i] = prog[i];
    dut.mem.mem[100] = 16'd300;
    dut.rf.registers[0] = 16'h8000;
    dut.rf.registers[1] = 16'h0000;
    dut.rf.registers[2] = 16'h0007;
    dut.rf.registers[3] = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      wait_ready(cyc, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL edge_timeout: txn %0d saw no ready in %0d cycles, required a pulse", i, cyc);
        return;
      end
      obs = (loc[i] < 4) ? dut.rf.registers[loc[i]] : dut.mem.mem[250];
      $display("edge txn %0d: instr=%h result=%h cycles=%0d", i, prog[i], obs, cyc);
      total++;
      if (obs !== expv[i]) begin
        bad++;
        $display("FAIL edge_result%0d: got %h, required %h", i, obs, expv[i]);
      end
    end
    total++;
    if (dut.PC !== 8'd6) begin bad++; $display("FAIL edge_pc: got %0d, required 6", dut.PC); end
  endtask

  task automatic test_pc_wrap;
    int cyc;
    bit ok;
    fill_nop();
    do_reset();
    dut.PC = 8'hFF;
    dut.mem.mem[255] = enc_r(3'b000, 2'd0, 2'd1, 2'd1);
    dut.rf.registers[1] = 16'd21;
    wait_ready(cyc, ok);
    $display("wrap txn 0: PC=%h x0=%h cycles=%0d", dut.PC, dut.rf.registers[0], cyc);
    total++;
    if (!ok || dut.PC !== 8'd0) begin bad++; $display("FAIL wrap_pc: got %h ok=%0d, required 00", dut.PC, ok); end
    total++;
    if (dut.rf.registers[0] !== 16'h002A) begin bad++; $display("FAIL wrap_result: got %h, required 002a", dut.rf.registers[0]); end
    wait_ready(cyc, ok);
    $display("wrap txn 1: PC=%h cycles=%0d", dut.PC, cyc);
    total++;
    if (!ok || dut.PC !== 8'd1) begin bad++; $display("FAIL wrap_next_pc: got %h ok=%0d, required 01", dut.PC, ok); end
  endtask

  task automatic test_reset_mid_mul;
    int cyc;
    int ready_hi;
    bit ok;
    ready_hi = 0;
    fill_nop();
    do_reset();
    dut.mem.mem[0] = enc_r(3'b010, 2'd2, 2'd0, 2'd1);
    dut.rf.registers[0] = 16'd3;
    dut.rf.registers[1] = 16'd5;
    dut.rf.registers[2] = 16'h1234;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dut.ready !== 1'b0) ready_hi++;
    end
    $display("abort txn: PC=%h ready=%b x2=%h", dut.PC, dut.ready, dut.rf.registers[2]);
    total++;
    if (dut.PC !== 8'd0) begin bad++; $display("FAIL abort_pc: got %h, required 00", dut.PC); end
    total++;
    if (ready_hi !== 0) begin bad++; $display("FAIL abort_ready: high %0d cycles, required 0", ready_hi); end
    total++;
    if (dut.rf.registers[2] !== 16'h0000) begin bad++; $display("FAIL abort_rd: got %h, required 0000", dut.rf.registers[2]); end
    @(negedge clk);
    reset = 1'b0;
    dut.mem.mem[0] = enc_r(3'b000, 2'd2, 2'd0, 2'd1);
    dut.rf.registers[0] = 16'd3;
    dut.rf.registers[1] = 16'd5;
    wait_ready(cyc, ok);
    $display("restart txn: PC=%h x2=%h cycles=%0d", dut.PC, dut.rf.registers[2], cyc);
    total++;
    if (!ok || cyc !== 4) begin bad++; $display("FAIL restart_latency: got %0d cycles ok=%0d, required 4", cyc, ok); end
    total++;
    if (dut.rf.registers[2] !== 16'h0008) begin bad++; $display("FAIL restart_result: got %h, required 0008", dut.rf.registers[2]); end
    total++;
    if (dut.PC !== 8'd1) begin bad++; $display("FAIL restart_pc: got %h, required 01", dut.PC); end
  endtask

  task automatic test_opcode_111;
    int cyc;
    bit ok;
    fill_nop();
    do_reset();
    dut.mem.mem[0] = 16'hE000;
    dut.rf.registers[0] = 16'd77;
    wait_ready(cyc, ok);
    $display("op111 txn 0: PC=%h cycles=%0d", dut.PC, cyc);
    total++;
    if (!ok || dut.PC !== 8'd1) begin bad++; $display("FAIL op111_pc: got %h ok=%0d, required 01", dut.PC, ok); end
`ifdef CTRL_HALT_EN
    begin
      int pc_moves;
      int pulses;
      pc_moves = 0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (dut.PC !== 8'd1) pc_moves++;
        if (dut.ready !== 1'b0) pulses++;
      end
      $display("halt txn: PC=%h pc_moves=%0d pulses=%0d", dut.PC, pc_moves, pulses);
      total++;
      if (pc_moves !== 0) begin bad++; $display("FAIL halt_pc_frozen: moved %0d cycles, required 0", pc_moves); end
      total++;
      if (pulses !== 0) begin bad++; $display("FAIL halt_ready: %0d extra high cycles, required 0", pulses); end
    end
`else
    total++;
    if (dut.rf.registers[0] !== 16'd77) begin bad++; $display("FAIL op111_regs: got %h, required 004d", dut.rf.registers[0]); end
    wait_ready(cyc, ok);
    $display("op111 txn 1: PC=%h cycles=%0d", dut.PC, cyc);
    total++;
    if (!ok || dut.PC !== 8'd2) begin bad++; $display("FAIL op111_continue: got %h ok=%0d, required 02", dut.PC, ok); end
`endif
  endtask

  initial begin
    test_reset();
    test_program();
    test_div_edges();
    test_pc_wrap();
    test_reset_mid_mul();
    test_opcode_111();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
